// File: rtl/addsub_arbiter_pkg.sv
// Shared constants, result-entry payload and helpers for the add/sub arbiter.
package addsub_arbiter_pkg;

  localparam int unsigned ADDSUB_W = 16;
  localparam int unsigned ID_MAX_W = 3;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // One result FIFO entry; id is sized for the largest legal requester count.
  typedef struct packed {
    logic [ADDSUB_W-1:0] data;
    logic [ID_MAX_W-1:0] id;
  } res_entry_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester/consumer bundle between the DSP channels and the shared add/sub arbiter.
interface addsub_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  import addsub_arbiter_pkg::*;

  localparam int unsigned IDW = clog2(NREQ);

  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          op_add_sub;
  logic [NREQ*ADDSUB_W-1:0] op_a;
  logic [NREQ*ADDSUB_W-1:0] op_b;
  logic [NREQ-1:0]          ack;
  logic                     res_valid;
  logic                     res_ready;
  logic [ADDSUB_W-1:0]      res_data;
  logic [IDW-1:0]           res_id;
  logic                     busy;

  modport slave (
    input  req, op_add_sub, op_a, op_b, res_ready,
    output ack, res_valid, res_data, res_id, busy
  );

  modport master (
    output req, op_add_sub, op_a, op_b, res_ready,
    input  ack, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/addsub_arbiter_addsub.sv
// Registered 16-bit add/subtract datapath, one clock of latency, result modulo 2^16.
module mylpm_addsub
  import addsub_arbiter_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_add_sub,
  input  logic [ADDSUB_W-1:0] i_dataa,
  input  logic [ADDSUB_W-1:0] i_datab,
  output logic [ADDSUB_W-1:0] o_result
);

  logic [ADDSUB_W-1:0] r_result;
  logic [ADDSUB_W-1:0] w_result;

  always_comb begin
    w_result = i_dataa - i_datab;
    if (i_add_sub == OP_ADD) w_result = i_dataa + i_datab;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_result <= '0;
    else          r_result <= w_result;
  end

  assign o_result = r_result;

endmodule

// File: rtl/addsub_arbiter_rr_pick.sv
// Round-robin picker: first asserted request searching upward from ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant_c,
  output logic [IDW-1:0]  o_idx_c,
  output logic            o_valid_c
);

  logic [IDW-1:0]  w_cand;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_found;

  always_comb begin
    w_cand  = '0;
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDW'((32'(i_ptr) + k) % NREQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        w_idx           = w_cand;
        w_grant[w_cand] = 1'b1;
      end
    end
  end

  assign o_grant_c = w_grant;
  assign o_idx_c   = w_idx;
  assign o_valid_c = w_found;

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one registered add/sub among NREQ requesters; tagged results leave
// through a small ready/valid FIFO, with grants credit-gated on FIFO space.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  addsub_arbiter_if.slave  bus
);

  localparam int unsigned IDW = clog2(NREQ);
  localparam int unsigned PW  = clog2(DEPTH);
  localparam int unsigned CW  = clog2(DEPTH + 1);

  logic [IDW-1:0]      r_ptr;
  logic                r_inflight;
  logic [IDW-1:0]      r_inflight_id;
  res_entry_t          r_mem [DEPTH];
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic                r_res_valid;
  logic                r_busy;

  logic                w_gate;
  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_idx;
  logic                w_grant_any;
  logic                w_add_sub;
  logic [ADDSUB_W-1:0] w_a;
  logic [ADDSUB_W-1:0] w_b;
  logic [ADDSUB_W-1:0] w_sum;
  logic [IDW-1:0]      w_ptr_nxt;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_count_nxt;
  logic [PW-1:0]       w_rd_nxt;
  logic [PW-1:0]       w_wr_nxt;

  // Credit gate counts the result still inside the adder as occupying a slot.
  assign w_gate = ((CW+1)'(r_count) + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .i_en      (w_gate & reset_n),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_valid_c (w_grant_any)
  );

  assign bus.ack = w_grant;

  // Adder inputs follow the picked index every clock; only inflight says whether it counts.
  always_comb begin
    w_add_sub = bus.op_add_sub[w_idx];
    w_a       = bus.op_a[32'(w_idx)*ADDSUB_W +: ADDSUB_W];
    w_b       = bus.op_b[32'(w_idx)*ADDSUB_W +: ADDSUB_W];
  end

  mylpm_addsub u_addsub (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_add_sub (w_add_sub),
    .i_dataa   (w_a),
    .i_datab   (w_b),
    .o_result  (w_sum)
  );

  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_push      = r_inflight;
    w_pop       = r_res_valid & bus.res_ready;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_rd_nxt    = r_rd_ptr;
    w_wr_nxt    = r_wr_ptr;
    if (w_grant_any) begin
      w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
    end
    if (w_push) begin
      w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    end
    if (w_pop) begin
      w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr         <= '0;
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ptr         <= w_ptr_nxt;
      r_inflight    <= w_grant_any;
      r_inflight_id <= w_idx;
      r_rd_ptr      <= w_rd_nxt;
      r_wr_ptr      <= w_wr_nxt;
      r_count       <= w_count_nxt;
      r_res_valid   <= (w_count_nxt != '0);
      r_busy        <= w_grant_any | (w_count_nxt != '0);
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{data: w_sum, id: ID_MAX_W'(r_inflight_id)};
      end
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_mem[r_rd_ptr].data;
  assign bus.res_id    = IDW'(r_mem[r_rd_ptr].id);
  assign bus.busy      = r_busy;

endmodule
